cic_integrator_decimator: RTL and testbench

Integrator cascade and rate-R downsampler forming the front half of the CIC decimation filter. It sits directly upstream of the `differentiator` comb stage. It accumulates every valid input sample through STAGES integrators at the input rate. It emits one full-precision sample, with a one-cycle `ready` pulse, every RATE accepted inputs; that pulse drives the comb stage's `valid`.

---
 rtl/cic_integrator_decimator_pkg.sv | 27 ++
 rtl/cic_integrator_decimator_integrator.sv | 34 +++
 rtl/cic_integrator_decimator.sv | 105 ++++++++++
 tb/tb_cic_integrator_decimator.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cic_integrator_decimator_pkg.sv
// Shared CIC helpers: accumulator width growth and sign extension.
// Used by both the integrator/decimator half and the downstream comb stage.
package cic_pkg;

    localparam int unsigned SEXT_BITS = 64;

    // Register width needed so that integrator wrap-around is cancelled exactly by the comb.
    function automatic int unsigned cic_acc_bits(
        input int unsigned in_bits,
        input int unsigned stages,
        input int unsigned rate,
        input int unsigned diff_delay
    );
        return in_bits + stages * $clog2(rate * diff_delay);
    endfunction

    // Sign-extend the low from_bits of x to SEXT_BITS; callers cast down to their width.
    function automatic logic [SEXT_BITS-1:0] cic_sext(
        input logic [SEXT_BITS-1:0] x,
        input int unsigned          from_bits
    );
        logic [SEXT_BITS-1:0] sh;
        sh = x << (SEXT_BITS - from_bits);
        return SEXT_BITS'($signed(sh) >>> (SEXT_BITS - from_bits));
    endfunction

endpackage

// File: rtl/cic_integrator_decimator_integrator.sv
// One CIC integrator stage: modulo-2^W accumulator with enable and synchronous clear.
module cic_integrator #(
    parameter int unsigned W = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] add_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    // Accumulate on enable; overflow wraps by design.
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + add_i;
        end
    end

    // Accumulator register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cic_integrator_decimator.sv
// CIC integrator cascade plus rate-RATE downsampler (front half of the CIC decimator).
// Optional macro CIC_INTEG_ROUND_EN: round-half-up instead of truncation when OUT_BITS < ACC_BITS.
module cic_integrator_decimator
    import cic_pkg::*;
#(
    parameter int unsigned STAGES     = 3,
    parameter int unsigned RATE       = 4,
    parameter int unsigned DIFF_DELAY = 2,
    parameter int unsigned IN_BITS    = 10,
    parameter int unsigned ACC_BITS   = cic_acc_bits(IN_BITS, STAGES, RATE, DIFF_DELAY),
    parameter int unsigned OUT_BITS   = ACC_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_BITS-1:0]  stream_in,
    input  logic                valid,
    output logic [OUT_BITS-1:0] stream_out,
    output logic                ready
);

    localparam int unsigned          PH_BITS = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [PH_BITS-1:0]   PH_LAST = PH_BITS'(RATE - 1);

    logic [ACC_BITS-1:0] acc_w [STAGES];
    logic [ACC_BITS-1:0] add_w [STAGES];
    logic [ACC_BITS-1:0] last_sum_c;
    logic [OUT_BITS-1:0] reduced_c;

    logic [PH_BITS-1:0]  phase_q,      phase_d;
    logic [OUT_BITS-1:0] stream_out_q, stream_out_d;
    logic                ready_q,      ready_d;

    // Integrator cascade; each stage adds the pre-edge value of the stage before it.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign add_w[k] = ACC_BITS'(cic_sext(SEXT_BITS'(stream_in), IN_BITS));
        end else begin : g_chain
            assign add_w[k] = acc_w[k-1];
        end

        cic_integrator #(
            .W (ACC_BITS)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (valid),
            .add_i (add_w[k]),
            .acc_o (acc_w[k])
        );
    end

    // Value the last accumulator takes on this edge.
    assign last_sum_c = acc_w[STAGES-1] + add_w[STAGES-1];

    // Reduce the full-precision sum to the output width.
    if (OUT_BITS == ACC_BITS) begin : g_full
        assign reduced_c = last_sum_c;
    end else begin : g_cut
`ifdef CIC_INTEG_ROUND_EN
        localparam logic [ACC_BITS-1:0] HALF = ACC_BITS'(1) << (ACC_BITS - OUT_BITS - 1);
        logic [ACC_BITS-1:0] rounded_c;
        logic                unused_lsb_c;
        assign rounded_c    = last_sum_c + HALF;
        assign reduced_c    = rounded_c[ACC_BITS-1 -: OUT_BITS];
        assign unused_lsb_c = ^{rounded_c[ACC_BITS-OUT_BITS-1:0], last_sum_c[ACC_BITS-OUT_BITS-1:0]};
`else
        logic unused_lsb_c;
        assign reduced_c    = last_sum_c[ACC_BITS-1 -: OUT_BITS];
        assign unused_lsb_c = ^last_sum_c[ACC_BITS-OUT_BITS-1:0];
`endif
    end

    // Decimation phase and output capture on the RATE-th accepted sample.
    always_comb begin
        phase_d      = phase_q;
        stream_out_d = stream_out_q;
        ready_d      = 1'b0;
        if (valid) begin
            if (phase_q == PH_LAST) begin
                phase_d      = '0;
                stream_out_d = reduced_c;
                ready_d      = 1'b1;
            end else begin
                phase_d = phase_q + PH_BITS'(1);
            end
        end
    end

    // Phase counter and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q      <= '0;
            stream_out_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            stream_out_q <= stream_out_d;
            ready_q      <= ready_d;
        end
    end

    assign stream_out = stream_out_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_cic_integrator_decimator.sv
// Directed bench for cic_integrator_decimator: reset, step, impulse, valid gaps, wrap, reduction.
module tb_cic_integrator_decimator;

    localparam int unsigned W3  = 19;
    localparam int unsigned W2  = 16;
    localparam int unsigned W2R = 14;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           valid;
    logic [9:0]     stream_in;
    logic [W3-1:0]  out3;
    logic [W2-1:0]  out2;
    logic [W2R-1:0] out2r;
    logic           rdy3, rdy2, rdy2r;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;

    always #5 clk = ~clk;

    cic_integrator_decimator u_s3 (
        .clk (clk), .rst_n (rst_n), .stream_in (stream_in), .valid (valid),
        .stream_out (out3), .ready (rdy3)
    );

    cic_integrator_decimator #(.STAGES(2)) u_s2 (
        .clk (clk), .rst_n (rst_n), .stream_in (stream_in), .valid (valid),
        .stream_out (out2), .ready (rdy2)
    );

    cic_integrator_decimator #(.STAGES(2), .OUT_BITS(W2R)) u_s2r (
        .clk (clk), .rst_n (rst_n), .stream_in (stream_in), .valid (valid),
        .stream_out (out2r), .ready (rdy2r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_acc = 0;
    endtask

    // Optional idle gap (junk data, valid low), then one accepted sample; checks the pulse pattern.
    task automatic drive(input logic [9:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            valid     = 1'b0;
            stream_in = 10'($urandom);
            tick();
            check("idle_ready", 32'(rdy3), 32'd0);
        end
        valid     = 1'b1;
        stream_in = d;
        tick();
        valid     = 1'b0;
        n_acc++;
        check("ready_pattern", 32'(rdy3), (n_acc % 4 == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_imp [3];
        logic [31:0] exp_round;
        logic [W3-1:0] x, y0, y1, y2;
        logic [W3-1:0] z0a, z0b, z1a, z1b, z2a, z2b;
        int k;

        exp_imp[0] = 32'd3;
        exp_imp[1] = 32'd21;
        exp_imp[2] = 32'd55;
`ifdef CIC_INTEG_ROUND_EN
        exp_round = 32'd2;
`else
        exp_round = 32'd1;
`endif

        // Reset held with valid high and random data.
        rst_n = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stream_in = 10'($urandom);
            tick();
            check("rst_out", 32'(out3), 32'd0);
            check("rst_ready", 32'(rdy3), 32'd0);
        end
        rst_n = 1'b1;
        valid = 1'b0;
        n_acc = 0;

        // Step of ones: first pulse exactly after 4 valids.
        for (int i = 0; i < 4; i++) drive(10'd1, 0);
        check("step_s3_out", 32'(out3), 32'd4);
        check("step_s2_out", 32'(out2), 32'd6);
        check("step_s2_ready", 32'(rdy2), 32'd1);
        check("step_round_out", 32'(out2r), exp_round);
        tick();
        check("step_ready_drop", 32'(rdy3), 32'd0);
        check("step_out_hold", 32'(out3), 32'd4);

        // Impulse, valid continuous.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive((i == 0) ? 10'd1 : 10'd0, 0);
            if (n_acc % 4 == 0) check("impulse_out", 32'(out3), exp_imp[n_acc/4-1]);
        end

        // Impulse with random valid gaps: same values, same pulse count.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive((i == 0) ? 10'd1 : 10'd0, int'($urandom_range(0, 3)));
            if (n_acc % 4 == 0) check("gap_out", 32'(out3), exp_imp[n_acc/4-1]);
        end

        // Sustained 511: accumulators wrap, reference comb must see DC gain 512.
        do_reset();
        z0a = '0; z0b = '0; z1a = '0; z1b = '0; z2a = '0; z2b = '0;
        k = 0;
        for (int i = 0; i < 2000; i++) begin
            drive(10'd511, 0);
            if (n_acc % 4 == 0) begin
                x  = out3;
                y0 = x  - z0b; z0b = z0a; z0a = x;
                y1 = y0 - z1b; z1b = z1a; z1a = y0;
                y2 = y1 - z2b; z2b = z2a; z2a = y1;
                if (k >= 8) check("wrap_comb", 32'(y2), 32'd261632);
                k++;
            end
        end
        check("wrap_pulse_count", 32'(k), 32'd500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
